// File: rtl/motor_mixer.sv
// Quad motor mixer: thrust plus pitch/roll/yaw terms become four slew-limited,
// saturated 11-bit speeds, computed one motor per cycle on a shared datapath.
module motor_mixer #(
  parameter logic [10:0] MIN_RUN   = 11'd200,
  parameter logic [10:0] CAL_SPEED = 11'd432,
  parameter logic [10:0] MAX_STEP  = 11'd64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld,
  input  logic [8:0]        thrst,
  input  logic signed [9:0] ptch_term,
  input  logic signed [9:0] roll_term,
  input  logic signed [9:0] yaw_term,
  input  logic              inertial_cal,
  output logic [10:0]       frnt_spd,
  output logic [10:0]       bck_spd,
  output logic [10:0]       lft_spd,
  output logic [10:0]       rght_spd,
  output logic              wrt,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, FRNT, BCK, LFT, RGHT, WRT} state_t;

  state_t state_q, state_d;

  logic [8:0]        thrst_q;
  logic signed [9:0] ptch_q, roll_q, yaw_q;
  logic              cal_q;
  logic              wrt_q, busy_q;
  logic [10:0]       spd_q [4];

  logic [1:0]         idx;
  logic               wr_en;
  logic signed [12:0] axis_s, yaw_s, target_s, sat_s, prev_s, up_s, dn_s, new_s;
  logic [10:0]        new_spd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wrt_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wrt_q   <= (state_d == WRT);
      busy_q  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = IDLE;
    idx     = 2'd0;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: state_d = vld ? FRNT : IDLE;
      FRNT: begin state_d = BCK;  idx = 2'd0; wr_en = 1'b1; end
      BCK:  begin state_d = LFT;  idx = 2'd1; wr_en = 1'b1; end
      LFT:  begin state_d = RGHT; idx = 2'd2; wr_en = 1'b1; end
      RGHT: begin state_d = WRT;  idx = 2'd3; wr_en = 1'b1; end
      WRT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Commands are only taken while idle; a strobe during an update is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      thrst_q <= '0;
      ptch_q  <= '0;
      roll_q  <= '0;
      yaw_q   <= '0;
      cal_q   <= 1'b0;
    end else if (state_q == IDLE && vld) begin
      thrst_q <= thrst;
      ptch_q  <= ptch_term;
      roll_q  <= roll_term;
      yaw_q   <= yaw_term;
      cal_q   <= inertial_cal;
    end
  end

  // Front/back use pitch, left/right use roll; front and left negate the axis,
  // front and back negate yaw.
  always_comb begin
    axis_s   = idx[1] ? {{3{roll_q[9]}}, roll_q} : {{3{ptch_q[9]}}, ptch_q};
    yaw_s    = {{3{yaw_q[9]}}, yaw_q};
    target_s = {2'b00, MIN_RUN} + {4'b0000, thrst_q}
             + (idx[0] ? axis_s : -axis_s)
             + (idx[1] ? yaw_s : -yaw_s);

    if (target_s[12])
      sat_s = 13'sd0;
    else if (target_s > 13'sd2047)
      sat_s = 13'sd2047;
    else
      sat_s = target_s;

    prev_s = {2'b00, spd_q[idx]};
    up_s   = prev_s + {2'b00, MAX_STEP};
    dn_s   = prev_s - {2'b00, MAX_STEP};

    if (sat_s > prev_s)
      new_s = (sat_s < up_s) ? sat_s : up_s;
    else if (sat_s < prev_s)
      new_s = (sat_s > dn_s) ? sat_s : dn_s;
    else
      new_s = prev_s;

    new_spd = cal_q ? CAL_SPEED : new_s[10:0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_motor
      always_ff @(posedge clk) begin
        if (rst)
          spd_q[gi] <= '0;
        else if (wr_en && idx == 2'(gi))
          spd_q[gi] <= new_spd;
      end
    end
  endgenerate

  assign frnt_spd = spd_q[0];
  assign bck_spd  = spd_q[1];
  assign lft_spd  = spd_q[2];
  assign rght_spd = spd_q[3];
  assign wrt      = wrt_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_motor_mixer.sv
// Bench for motor_mixer: three parameterisations share one input bus; table
// vectors go through a scoreboard queue, corner cases are hand-sequenced.
module tb_motor_mixer;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              vld_v [3];
  logic [8:0]        thrst_v = '0;
  logic signed [9:0] ptch_v = '0, roll_v = '0, yaw_v = '0;
  logic              cal_v = 1'b0;
  logic [10:0]       f_o [3], b_o [3], l_o [3], r_o [3];
  logic              wrt_o [3], busy_o [3];

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [43:0] sb [$];

  always #5 clk = ~clk;

  motor_mixer u_a (
    .clk(clk), .rst(rst), .vld(vld_v[0]), .thrst(thrst_v), .ptch_term(ptch_v),
    .roll_term(roll_v), .yaw_term(yaw_v), .inertial_cal(cal_v),
    .frnt_spd(f_o[0]), .bck_spd(b_o[0]), .lft_spd(l_o[0]), .rght_spd(r_o[0]),
    .wrt(wrt_o[0]), .busy(busy_o[0]));

  motor_mixer #(.MAX_STEP(11'd2047)) u_b (
    .clk(clk), .rst(rst), .vld(vld_v[1]), .thrst(thrst_v), .ptch_term(ptch_v),
    .roll_term(roll_v), .yaw_term(yaw_v), .inertial_cal(cal_v),
    .frnt_spd(f_o[1]), .bck_spd(b_o[1]), .lft_spd(l_o[1]), .rght_spd(r_o[1]),
    .wrt(wrt_o[1]), .busy(busy_o[1]));

  motor_mixer #(.MIN_RUN(11'd1500), .MAX_STEP(11'd2047)) u_c (
    .clk(clk), .rst(rst), .vld(vld_v[2]), .thrst(thrst_v), .ptch_term(ptch_v),
    .roll_term(roll_v), .yaw_term(yaw_v), .inertial_cal(cal_v),
    .frnt_spd(f_o[2]), .bck_spd(b_o[2]), .lft_spd(l_o[2]), .rght_spd(r_o[2]),
    .wrt(wrt_o[2]), .busy(busy_o[2]));

  typedef struct {
    int sel;
    bit rst_first;
    bit cal;
    int t, p, r, y;
    int ef, eb, el, er;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) vld_v[i] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive(input bit cal, input int t, input int p, input int r, input int y);
    cal_v = cal; thrst_v = 9'(t); ptch_v = 10'(p); roll_v = 10'(r); yaw_v = 10'(y);
  endtask

  task automatic apply(input int sel, input bit cal, input int t, input int p, input int r,
                       input int y, input int ef, input int eb, input int el, input int er);
    int cyc;
    logic [43:0] exp;
    sb.push_back({11'(ef), 11'(eb), 11'(el), 11'(er)});
    drive(cal, t, p, r, y);
    vld_v[sel] = 1'b1;
    @(negedge clk);
    vld_v[sel] = 1'b0;
    cyc = 1;
    while (!wrt_o[sel] && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("wrt_latency", cyc, 5);
    exp = sb.pop_front();
    check("frnt_spd", int'(f_o[sel]), int'(exp[43:33]));
    check("bck_spd",  int'(b_o[sel]), int'(exp[32:22]));
    check("lft_spd",  int'(l_o[sel]), int'(exp[21:11]));
    check("rght_spd", int'(r_o[sel]), int'(exp[10:0]));
    $display("txn dut=%0d cal=%0d thrst=%0d p=%0d r=%0d y=%0d -> f=%0d b=%0d l=%0d r=%0d lat=%0d",
             sel, cal, t, p, r, y, f_o[sel], b_o[sel], l_o[sel], r_o[sel], cyc);
    @(negedge clk);
    check("wrt_one_cycle", int'(wrt_o[sel]), 0);
    check("busy_after", int'(busy_o[sel]), 0);
  endtask

  initial begin
    int wrts, busys;
    for (int i = 0; i < 3; i++) vld_v[i] = 1'b0;

    //        sel rst cal  thrst  p     r     y      frnt  bck   lft   rght
    vecs[0]  = '{0, 1, 0, 100,    0,    0,    0,     64,   64,   64,   64};
    vecs[1]  = '{0, 0, 0, 100,    0,    0,    0,    128,  128,  128,  128};
    vecs[2]  = '{0, 0, 0, 100,    0,    0,    0,    192,  192,  192,  192};
    vecs[3]  = '{0, 0, 0, 100,    0,    0,    0,    256,  256,  256,  256};
    vecs[4]  = '{0, 0, 0, 100,    0,    0,    0,    300,  300,  300,  300};
    vecs[5]  = '{0, 0, 0, 100,    0,    0,    0,    300,  300,  300,  300};
    vecs[6]  = '{0, 0, 0,   0,    0,    0,    0,    236,  236,  236,  236};
    vecs[7]  = '{0, 0, 0,   0,    0,    0,    0,    200,  200,  200,  200};
    vecs[8]  = '{1, 1, 0, 100,   20,  -10,    5,    275,  315,  315,  295};
    vecs[9]  = '{1, 1, 0,   0,  511,    0,  511,      0,  200,  711,  711};
    vecs[10] = '{2, 1, 0, 511, -512,    0, -512,   2047, 2011, 1499, 1499};
    vecs[11] = '{2, 0, 0,   0,  511, -512,  511,    478, 1500, 2047, 1499};
    vecs[12] = '{0, 1, 1, 511,  511, -512,  511,    432,  432,  432,  432};
    vecs[13] = '{0, 0, 0, 100,    0,    0,    0,    368,  368,  368,  368};
    vecs[14] = '{0, 0, 0, 100,    0,  100,    0,    304,  304,  304,  400};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_frnt", int'(f_o[i]), 0);
      check("rst_bck",  int'(b_o[i]), 0);
      check("rst_lft",  int'(l_o[i]), 0);
      check("rst_rght", int'(r_o[i]), 0);
      check("rst_wrt",  int'(wrt_o[i]), 0);
      check("rst_busy", int'(busy_o[i]), 0);
    end

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].rst_first) do_reset();
      apply(vecs[i].sel, vecs[i].cal, vecs[i].t, vecs[i].p, vecs[i].r, vecs[i].y,
            vecs[i].ef, vecs[i].eb, vecs[i].el, vecs[i].er);
    end

    // Second strobe two cycles into an update must be ignored.
    do_reset();
    wrts = 0; busys = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 0) drive(1'b0, 100, 0, 0, 0);
      else drive(1'b1, 511, 300, -200, 100);
      vld_v[0] = (c == 0 || c == 2);
      @(negedge clk);
      wrts += int'(wrt_o[0]);
      busys += int'(busy_o[0]);
    end
    vld_v[0] = 1'b0;
    check("ignored_vld_wrt_count", wrts, 1);
    check("ignored_vld_busy_cycles", busys, 5);
    check("ignored_vld_frnt", int'(f_o[0]), 64);
    check("ignored_vld_rght", int'(r_o[0]), 64);
    $display("txn busy-strobe: wrts=%0d busy_cycles=%0d f=%0d", wrts, busys, f_o[0]);

    // Reset right after the front motor is written.
    do_reset();
    drive(1'b0, 100, 0, 0, 0);
    vld_v[0] = 1'b1;
    @(negedge clk);
    vld_v[0] = 1'b0;
    @(negedge clk);
    check("mid_frnt_written", int'(f_o[0]), 64);
    check("mid_bck_held", int'(b_o[0]), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_frnt", int'(f_o[0]), 0);
    check("mid_rst_busy", int'(busy_o[0]), 0);
    check("mid_rst_wrt", int'(wrt_o[0]), 0);
    wrts = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      wrts += int'(wrt_o[0]);
    end
    check("mid_rst_no_wrt", wrts, 0);
    $display("txn mid-update reset: f=%0d busy=%0d wrts=%0d", f_o[0], busy_o[0], wrts);
    apply(0, 1'b0, 100, 0, 0, 0, 64, 64, 64, 64);

    // rst and vld together: command dropped.
    rst = 1'b1;
    drive(1'b0, 100, 0, 0, 0);
    vld_v[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vld_v[0] = 1'b0;
    wrts = 0; busys = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      wrts += int'(wrt_o[0]);
      busys += int'(busy_o[0]);
    end
    check("rst_vld_no_wrt", wrts, 0);
    check("rst_vld_no_busy", busys, 0);
    check("rst_vld_frnt", int'(f_o[0]), 0);
    $display("txn rst+vld: wrts=%0d busy_cycles=%0d f=%0d", wrts, busys, f_o[0]);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
